// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the main-memory port arbiter.
//   arb_state_e     - arbiter FSM state encoding (IDLE/ISSUE/WAIT)
//   DEF_DATA_W/ADDR_W - default memory word and address widths
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i        - per-port request vector
//   last_grant_i - index of the most recently granted port
//   winner_o     - first requesting port after last_grant_i, wrapping
//   any_req_o    - at least one request present (winner_o valid)
module rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic [IDX_W-1:0]     winner_o,
    output logic                 any_req_o
);

    // Scan offsets from farthest to nearest so the nearest requester after
    // last_grant_i is the one left standing; no early-exit flag needed.
    always_comb begin
        int idx;
        idx       = 0;
        winner_o  = '0;
        any_req_o = |req_i;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last_grant_i) + k) % NUM_PORTS;
            if (req_i[idx]) begin
                winner_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of a single-port synchronous memory
// between NUM_PORTS requesters using a req/gnt/rvalid handshake.
//   clk, rst        - clock, asynchronous active-high reset
//   req/we          - per-port request and write enable
//   addr/wdata      - per-port address/write data, port i at [i*W +: W]
//   gnt             - one-cycle accept pulse (write completion for writes)
//   rvalid/rdata    - one-cycle read-valid pulse and shared read data
//   busy            - arbiter is not idle
//   mem_addr/mem_data/mem_wren/mem_q - memory interface
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int READ_LATENCY = 1,
    parameter int IDX_W        = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_q
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    arb_state_e             state_q;
    logic [IDX_W-1:0]       sel_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic                   op_we_q;
    logic [LAT_W-1:0]       lat_cnt_q;
    logic [NUM_PORTS-1:0]   gnt_q;
    logic [NUM_PORTS-1:0]   rvalid_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_data_q;
    logic                   mem_wren_q;

    logic [IDX_W-1:0]       winner;
    logic                   any_req;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_req_o    (any_req)
    );

    // gnt/mem_wren are set on the edge entering ISSUE so they are high for
    // exactly the ISSUE cycle; mem_addr/mem_data are only reloaded on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            op_we_q      <= 1'b0;
            lat_cnt_q    <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
        end else begin
            gnt_q      <= '0;
            rvalid_q   <= '0;
            mem_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q        <= winner;
                        last_grant_q <= winner;
                        mem_addr_q   <= addr[int'(winner)*ADDR_W +: ADDR_W];
                        mem_data_q   <= wdata[int'(winner)*DATA_W +: DATA_W];
                        op_we_q      <= we[winner];
                        mem_wren_q   <= we[winner];
                        gnt_q        <= NUM_PORTS'(1) << winner;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_we_q) begin
                        state_q <= IDLE;
                    end else begin
                        lat_cnt_q <= LAT_W'(READ_LATENCY - 1);
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end else begin
                        rdata_q  <= mem_q;
                        rvalid_q <= NUM_PORTS'(1) << sel_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic against a transaction-level
// reference model (rotation + fixed occupancy arithmetic) with a behavioural
// memory of READ_LATENCY register stages.
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int L  = 3;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, mem_data, mem_q;
    logic [AW-1:0]   mem_addr;
    logic            busy, mem_wren;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        case (i)
            'h01:    return 16'h1111;
            'h02:    return 16'h2222;
            'h20:    return 16'h0ABC;
            default: return DW'(i * 257) ^ 16'hA5C3;
        endcase
    endfunction

    // Behavioural memory: samples address/data on the edge, data appears
    // L edges later.
    logic [DW-1:0] dmem [256];
    logic [DW-1:0] pipe [L];
    assign mem_q = pipe[L-1];
    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = init_val(i);
        for (int i = 0; i < L; i++) pipe[i] = '0;
        forever begin
            @(posedge clk);
            if (mem_wren) dmem[mem_addr] <= mem_data;
            pipe[0] <= dmem[mem_addr];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int nchk = 0, nfail = 0;
    int cyc = 0, free_at = 0, m_last = N - 1;
    int rq_cyc = 0, gnt_cyc = 0, rv_cyc = 0;
    bit gaps = 1'b0;
    logic [DW-1:0] m_mem [256];
    logic [DW-1:0] m_rdata = '0;
    logic [N-1:0]  e_gnt [64], e_rv [64];
    bit            e_busy [64], e_wren [64], e_iss [64];
    logic [AW-1:0] e_addr [64];
    logic [DW-1:0] e_wd [64], e_rd [64];
    op_t           pq [N][$];
    op_t           cur [N];
    bit            cur_v [N], adv [N];
    int            gq [$];
    logic [DW-1:0] gotq [N][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_slot(input int s);
        e_gnt[s] = '0; e_rv[s] = '0; e_busy[s] = 0; e_wren[s] = 0; e_iss[s] = 0;
        e_addr[s] = '0; e_wd[s] = '0; e_rd[s] = '0;
    endtask

    // Compare this cycle against the schedule, then let the model accept a
    // new transaction if the port is free.
    task automatic check_and_model();
        int s = cyc % 64;
        int w = -1;
        chk("gnt", 32'(gnt), 32'(e_gnt[s]));
        chk("rvalid", 32'(rvalid), 32'(e_rv[s]));
        chk("busy", 32'(busy), 32'(e_busy[s]));
        chk("mem_wren", 32'(mem_wren), 32'(e_wren[s]));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (e_rv[s] != '0) m_rdata = e_rd[s];
        chk("rdata", 32'(rdata), 32'(m_rdata));
        if (e_iss[s]) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr[s]));
            if (e_wren[s]) chk("mem_data", 32'(mem_data), 32'(e_wd[s]));
        end
        for (int p = 0; p < N; p++) begin
            if (gnt[p]) begin gq.push_back(p); gnt_cyc = cyc; end
            if (rvalid[p]) begin gotq[p].push_back(rdata); rv_cyc = cyc; end
        end
        clear_slot(s);
        if (!rst && cyc >= free_at && req != '0) begin
            for (int k = 1; k <= N && w < 0; k++)
                if (req[(m_last + k) % N]) w = (m_last + k) % N;
            s = (cyc + 1) % 64;
            e_gnt[s]  = N'(1 << w);
            e_busy[s] = 1;
            e_iss[s]  = 1;
            e_wren[s] = we[w];
            e_addr[s] = addr[w*AW +: AW];
            e_wd[s]   = wdata[w*DW +: DW];
            if (we[w]) begin
                m_mem[addr[w*AW +: AW]] = wdata[w*DW +: DW];
                free_at = cyc + 2;
            end else begin
                for (int j = 2; j <= 1 + L; j++) e_busy[(cyc + j) % 64] = 1;
                e_rv[(cyc + 2 + L) % 64] = N'(1 << w);
                e_rd[(cyc + 2 + L) % 64] = m_mem[addr[w*AW +: AW]];
                free_at = cyc + 2 + L;
            end
            m_last = w;
        end
    endtask

    // Requesters: hold an op until its gnt is seen, present the next one
    // from the following cycle (optionally after random gaps).
    task automatic drive();
        cyc++;
        for (int p = 0; p < N; p++) begin
            if (adv[p]) begin cur_v[p] = 0; adv[p] = 0; end
            if (!cur_v[p] && pq[p].size() != 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
                cur[p] = pq[p].pop_front();
                cur_v[p] = 1;
                rq_cyc = cyc;
            end
            if (cur_v[p] && gnt[p]) adv[p] = 1;
            req[p] = cur_v[p];
            we[p]  = cur_v[p] & cur[p].w;
            addr[p*AW +: AW]  = cur[p].a;
            wdata[p*DW +: DW] = cur[p].d;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_and_model();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.w = w; o.a = a; o.d = d;
        pq[p].push_back(o);
    endtask

    function automatic bit all_idle();
        for (int p = 0; p < N; p++) if (pq[p].size() != 0 || cur_v[p]) return 0;
        return cyc > free_at;
    endfunction

    task automatic run_idle(input int maxc);
        int k = 0;
        do begin step(); k++; end while (!all_idle() && k < maxc);
        chk("run_bound", 32'(k < maxc), 32'd1);
    endtask

    // Called at posedge+1: assert reset, check outputs clear at once, hold
    // two cycles, release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        for (int p = 0; p < N; p++) begin
            cur_v[p] = 0; adv[p] = 0; pq[p].delete(); gotq[p].delete();
        end
        req = '0; we = '0; addr = '0; wdata = '0;
        for (int s = 0; s < 64; s++) clear_slot(s);
        m_last = N - 1; m_rdata = '0; free_at = 0;
        gq.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
        for (int s = 0; s < 64; s++) clear_slot(s);
        @(posedge clk);
        #1;
        do_reset();

        // write then read back on port 0
        push(0, 1'b1, 8'h10, 16'hBEEF);
        push(0, 1'b0, 8'h10, 16'h0000);
        run_idle(100);
        chk("wr_rd_cnt", 32'(gotq[0].size()), 32'd1);
        chk("wr_rd_data", 32'(gotq[0][0]), 32'hBEEF);

        // two ports reading continuously: strict alternation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 8'h01, '0);
            push(1, 1'b0, 8'h02, '0);
        end
        run_idle(200);
        chk("alt_len", 32'(gq.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("alt_order", 32'(gq[i]), 32'(i % 2));
        for (int i = 0; i < 4; i++) begin
            chk("alt_p0", 32'(gotq[0][i]), 32'h1111);
            chk("alt_p1", 32'(gotq[1][i]), 32'h2222);
        end

        // ports 0 and 2 only: 0,2,0,2,... port 1 skipped
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, AW'(8'h30 + i), '0);
            push(2, 1'b0, AW'(8'h38 + i), '0);
        end
        run_idle(200);
        chk("skip_len", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("skip_order", 32'(gq[i]), 32'((i % 2) * 2));

        // single read latency: gnt +1, rvalid +2+L
        do_reset();
        push(0, 1'b0, 8'h33, '0);
        run_idle(100);
        chk("lat_gnt", 32'(gnt_cyc - rq_cyc), 32'd1);
        chk("lat_rvalid", 32'(rv_cyc - rq_cyc), 32'(2 + L));
        chk("lat_data", 32'(gotq[0][0]), 32'(init_val('h33)));

        // same-cycle write (port 1) and read (port 0) of 0x20
        do_reset();
        push(1, 1'b1, 8'h20, 16'h0042);
        push(0, 1'b0, 8'h20, '0);
        push(0, 1'b0, 8'h20, '0);
        run_idle(100);
        chk("conf_first", 32'(gq[0]), 32'd0);
        chk("conf_old", 32'(gotq[0][0]), 32'h0ABC);
        chk("conf_new", 32'(gotq[0][1]), 32'h0042);

        // random traffic with gaps, small address window for collisions
        do_reset();
        gaps = 1'b1;
        for (int i = 0; i < 150; i++)
            push($urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
                 AW'(8'h40 + $urandom_range(0, 15)), DW'($urandom));
        run_idle(6000);
        gaps = 1'b0;

        // reset while in WAIT: nothing delivered, then port 0 first again
        do_reset();
        push(0, 1'b0, 8'h05, '0);
        for (int k = 0; k < 20 && gq.size() == 0; k++) step();
        chk("wait_gnt_seen", 32'(gq.size()), 32'd1);
        step();
        step();
        chk("wait_busy", 32'(busy), 32'd1);
        do_reset();
        chk("abort_no_rvalid", 32'(gotq[0].size()), 32'd0);
        push(0, 1'b0, 8'h01, '0);
        push(1, 1'b0, 8'h02, '0);
        run_idle(100);
        chk("post_rst_first", 32'(gq[0]), 32'd0);
        chk("post_rst_second", 32'(gq[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
